// File: rtl/rv_pkg.sv
// Shared RV32 fetch-path definitions: instruction-length marker and halfword entry layout.
package rv_pkg;

   localparam logic [1:0] RV32_OPC_DET   = 2'b11;
   localparam int         INSTR_HW_WIDTH = 16;

   typedef struct packed {
      logic [INSTR_HW_WIDTH-1:0] data;
      logic [31:0]               pc;
      logic                      bp;
   } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_buffer.sv
// Instruction prefetch buffer: halfword FIFO between the fetcher and decode,
// presenting one complete RVC or 32-bit instruction at a time.
module rv_fetch_buffer
   import rv_pkg::*;
#(
   parameter int INSTR_BUF_ADDR_SIZE = 2
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_flush,
   input  logic        i_stall,
   input  logic        i_pc_select,
   input  logic        i_ack,
   input  logic [31:0] i_data,
   input  logic [31:0] i_fetch_pc,
   input  logic        i_branch_pred,
   output logic        o_free_dword_or_more,
   output logic [31:0] o_pc_incr,
   output logic [31:0] o_pc,
   output logic        o_branch_pred,
   output logic [31:0] o_instruction,
   output logic        o_ready
);

   localparam int          PTR_W = INSTR_BUF_ADDR_SIZE + 1;
   localparam int unsigned DEPTH = 2 ** PTR_W;

   fetch_entry_t     buf_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic [31:0]      fetch_pc_q;
   logic             bp_q;

   fetch_entry_t     h0;
   fetch_entry_t     h1;
   logic             is32;
   logic             complete;
   logic             clear;
   logic [1:0]       push_cnt;
   logic [1:0]       pop_cnt;

   assign h0    = buf_q[rd_ptr];
   assign h1    = buf_q[rd_ptr + PTR_W'(1)];
   assign is32  = (h0.data[1:0] == RV32_OPC_DET);
   assign clear = i_flush | i_pc_select;

   always_comb begin
      complete = is32 ? (count >= (PTR_W+1)'(2)) : (count != '0);
      o_ready  = complete & ~clear;

      o_instruction = is32 ? {h1.data, h0.data} : {16'h0, h0.data};
      o_pc          = h0.pc;
      o_branch_pred = h0.bp;

      // Data arriving now belongs to the address registered last cycle.
      push_cnt = '0;
      if (i_ack && !clear) begin
         push_cnt = fetch_pc_q[1] ? 2'd1 : 2'd2;
      end

      pop_cnt = '0;
      if (o_ready && !i_stall) begin
         pop_cnt = is32 ? 2'd2 : 2'd1;
      end

      o_pc_incr            = i_fetch_pc[1] ? 32'd2 : 32'd4;
      o_free_dword_or_more = (count <= (PTR_W+1)'(DEPTH - 4));
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         fetch_pc_q <= '0;
         bp_q       <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= i_fetch_pc;
         bp_q       <= i_branch_pred;
         if (clear) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
         end else begin
            if (push_cnt == 2'd2) begin
               buf_q[wr_ptr]              <= '{data: i_data[15:0],  pc: fetch_pc_q,         bp: bp_q};
               buf_q[wr_ptr + PTR_W'(1)]  <= '{data: i_data[31:16], pc: fetch_pc_q + 32'd2, bp: bp_q};
            end else if (push_cnt == 2'd1) begin
               buf_q[wr_ptr]              <= '{data: i_data[31:16], pc: fetch_pc_q,         bp: bp_q};
            end
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            count  <= count + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop_cnt);
         end
      end
   end

endmodule

// File: tb/tb_rv_fetch_buffer.sv
// Self-checking bench for rv_fetch_buffer: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_rv_fetch_buffer;

   localparam int DEPTH = 8;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_flush = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_pc_select = 1'b0;
   logic        i_ack = 1'b0;
   logic [31:0] i_data = '0;
   logic [31:0] i_fetch_pc = '0;
   logic        i_branch_pred = 1'b0;
   logic        o_free_dword_or_more;
   logic [31:0] o_pc_incr;
   logic [31:0] o_pc;
   logic        o_branch_pred;
   logic [31:0] o_instruction;
   logic        o_ready;

   int n_cmp = 0;
   int n_bad = 0;

   rv_fetch_buffer #(.INSTR_BUF_ADDR_SIZE(2)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_stall(i_stall),
      .i_pc_select(i_pc_select), .i_ack(i_ack), .i_data(i_data), .i_fetch_pc(i_fetch_pc),
      .i_branch_pred(i_branch_pred), .o_free_dword_or_more(o_free_dword_or_more),
      .o_pc_incr(o_pc_incr), .o_pc(o_pc), .o_branch_pred(o_branch_pred),
      .o_instruction(o_instruction), .o_ready(o_ready)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: a queue of halfwords, each carrying its PC and prediction bit.
   typedef struct {
      logic [15:0] d;
      logic [31:0] pc;
      logic        bp;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_fpc;
   logic        m_bp;

   function automatic logic m_ready();
      if (q.size() == 0) return 1'b0;
      if (q[0].d[1:0] == 2'b11 && q.size() < 2) return 1'b0;
      return !i_flush && !i_pc_select;
   endfunction

   always @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         q.delete();
         m_fpc = '0;
         m_bp  = 1'b0;
      end else begin
         logic rdy, big;
         rdy = m_ready();
         big = (q.size() > 0) && (q[0].d[1:0] == 2'b11);
         if (i_flush || i_pc_select) begin
            q.delete();
         end else begin
            if (rdy && !i_stall) begin
               void'(q.pop_front());
               if (big) void'(q.pop_front());
            end
            if (i_ack) begin
               if (!m_fpc[1]) begin
                  q.push_back('{d: i_data[15:0],  pc: m_fpc,         bp: m_bp});
                  q.push_back('{d: i_data[31:16], pc: m_fpc + 32'd2, bp: m_bp});
               end else begin
                  q.push_back('{d: i_data[31:16], pc: m_fpc, bp: m_bp});
               end
            end
            n_cmp++;
            if (q.size() > DEPTH) begin
               n_bad++;
               $display("FAIL overflow: occupancy %0d exceeds depth %0d", q.size(), DEPTH);
            end
         end
         m_fpc = i_fetch_pc;
         m_bp  = i_branch_pred;
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge i_clk) begin
      if (i_reset_n) begin
         logic        e_rdy, e_free;
         logic [31:0] e_incr, e_ins;
         e_rdy  = m_ready();
         e_free = (DEPTH - q.size()) >= 4;
         e_incr = i_fetch_pc[1] ? 32'd2 : 32'd4;
         n_cmp++;
         if (o_ready !== e_rdy || o_free_dword_or_more !== e_free || o_pc_incr !== e_incr) begin
            n_bad++;
            $display("FAIL model_ctl t=%0t: rdy=%b/%b free=%b/%b incr=%0h/%0h (got/exp)",
                     $time, o_ready, e_rdy, o_free_dword_or_more, e_free, o_pc_incr, e_incr);
         end
         if (e_rdy) begin
            e_ins = (q[0].d[1:0] == 2'b11) ? {q[1].d, q[0].d} : {16'h0, q[0].d};
            n_cmp++;
            if (o_instruction !== e_ins || o_pc !== q[0].pc || o_branch_pred !== q[0].bp) begin
               n_bad++;
               $display("FAIL model_head t=%0t: ins=%h/%h pc=%h/%h bp=%b/%b (got/exp)",
                        $time, o_instruction, e_ins, o_pc, q[0].pc, o_branch_pred, q[0].bp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic psel, input logic flush, input logic stall, input logic ack,
                       input logic [31:0] data, input logic [31:0] fpc, input logic bp);
      @(posedge i_clk); #1;
      i_pc_select = psel; i_flush = flush; i_stall = stall; i_ack = ack;
      i_data = data; i_fetch_pc = fpc; i_branch_pred = bp;
      @(negedge i_clk); #1;
   endtask

   task automatic chk_head(input string name, input logic [31:0] ins, input logic [31:0] pc);
      chk({name, "_rdy"}, 32'(o_ready), 32'd1);
      chk({name, "_ins"}, o_instruction, ins);
      chk({name, "_pc"}, o_pc, pc);
   endtask

   initial begin
      logic [31:0] w;
      #12;
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_ins", o_instruction, 32'h0);
      chk("rst_bp", 32'(o_branch_pred), 32'd0);
      chk("rst_free", 32'(o_free_dword_or_more), 32'd1);
      i_reset_n = 1'b1;

      // Aligned 32-bit word
      step(0, 0, 0, 0, '0, 32'h0, 0);
      step(0, 0, 0, 1, 32'h00500093, 32'h4, 0);
      chk("al_incr", o_pc_incr, 32'd4);
      step(0, 0, 0, 0, '0, 32'h4, 0);
      chk_head("al", 32'h00500093, 32'h0);
      step(0, 0, 0, 0, '0, 32'h4, 0);
      chk("al_empty", 32'(o_ready), 32'd0);

      // Two compressed in one word
      step(0, 0, 0, 0, '0, 32'h100, 0);
      step(0, 0, 0, 1, 32'h45014081, 32'h104, 0);
      step(0, 0, 0, 0, '0, 32'h104, 0);
      chk_head("c0", 32'h00004081, 32'h100);
      step(0, 0, 0, 0, '0, 32'h104, 0);
      chk_head("c1", 32'h00004501, 32'h102);

      // Misaligned redirect
      step(1, 0, 0, 0, '0, 32'h202, 0);
      chk("mis_incr", o_pc_incr, 32'd2);
      step(0, 0, 0, 1, 32'h45051234, 32'h204, 0);
      step(0, 0, 0, 0, '0, 32'h204, 0);
      chk_head("mis", 32'h00004505, 32'h202);

      // 32-bit instruction split across two words
      step(0, 0, 0, 0, '0, 32'h300, 0);
      step(0, 0, 0, 1, 32'h00934081, 32'h304, 0);
      step(0, 0, 0, 0, '0, 32'h304, 0);
      chk_head("sp_c", 32'h00004081, 32'h300);
      step(0, 0, 0, 0, '0, 32'h304, 0);
      chk("sp_wait", 32'(o_ready), 32'd0);
      step(0, 0, 0, 1, 32'h00000050, 32'h308, 0);
      chk("sp_wait2", 32'(o_ready), 32'd0);
      step(0, 0, 0, 0, '0, 32'h308, 0);
      chk_head("sp_32", 32'h00500093, 32'h302);
      step(0, 0, 0, 0, '0, 32'h308, 0);
      step(0, 0, 0, 0, '0, 32'h308, 0);

      // Stall while the buffer fills
      step(0, 0, 1, 0, '0, 32'h400, 1);
      for (int i = 0; i < 4; i++) begin
         w = 32'h20011001 + 32'(i) * 32'h00020002;
         step(0, 0, 1, 1, w, 32'h404 + 32'(i) * 32'd4, 1);
         if (i > 0) begin
            chk_head("st_head", 32'h00001001, 32'h400);
            chk("st_bp", 32'(o_branch_pred), 32'd1);
         end
      end
      step(0, 0, 1, 0, '0, 32'h414, 0);
      chk("st_full_free", 32'(o_free_dword_or_more), 32'd0);
      chk_head("st_full", 32'h00001001, 32'h400);

      // Flush coincident with ack
      step(0, 1, 0, 1, 32'h00500093, 32'h418, 0);
      chk("fl_rdy", 32'(o_ready), 32'd0);
      step(0, 0, 0, 0, '0, 32'h418, 0);
      chk("fl_rdy_next", 32'(o_ready), 32'd0);
      chk("fl_free", 32'(o_free_dword_or_more), 32'd1);

      // Asynchronous reset mid-stream
      step(0, 0, 0, 0, '0, 32'h500, 1);
      step(0, 0, 1, 1, 32'h00500093, 32'h504, 0);
      step(0, 0, 1, 0, '0, 32'h504, 0);
      chk_head("ar_pre", 32'h00500093, 32'h500);
      #2 i_reset_n = 1'b0;
      #1;
      chk("ar_rdy", 32'(o_ready), 32'd0);
      chk("ar_ins", o_instruction, 32'h0);
      chk("ar_pc", o_pc, 32'h0);
      chk("ar_free", 32'(o_free_dword_or_more), 32'd1);
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      step(0, 0, 0, 0, '0, 32'h0, 0);
      step(0, 0, 0, 0, '0, 32'h0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
